// File: rtl/counter_prog_if.sv
// rtl/counter_prog_if.sv - control/status bundle for the programmable counter
interface counter_prog_if #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
);
  logic               en;
  logic [1:0]         mode;
  logic               load;
  logic [WIDTH-1:0]   load_val;
  logic [PRESC_W-1:0] presc_div;
  logic [WIDTH-1:0]   max_val;
  logic [WIDTH-1:0]   cmp_val;
  logic [WIDTH-1:0]   count;
  logic               dir;
  logic               tick;
  logic               tc;
  logic               cmp_match;

  modport master (
    output en, mode, load, load_val, presc_div, max_val, cmp_val,
    input  count, dir, tick, tc, cmp_match
  );

  modport slave (
    input  en, mode, load, load_val, presc_div, max_val, cmp_val,
    output count, dir, tick, tc, cmp_match
  );
endinterface

// File: rtl/counter_prog.sv
// rtl/counter_prog.sv - programmable-modulus counter with prescaler, load, tc and compare
module counter_prog #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  counter_prog_if.slave bus
);
  typedef enum logic [1:0] {
    M_UP_WRAP   = 2'b00,
    M_DOWN_WRAP = 2'b01,
    M_UP_SAT    = 2'b10,
    M_PING_PONG = 2'b11
  } mode_e;

  logic [WIDTH-1:0]   r_count, w_count_nxt;
  logic [PRESC_W-1:0] r_p, w_p_nxt;
  logic               r_dir, w_dir_nxt;
  logic               r_tick, w_tick_nxt;
  logic               r_tc, w_tc_nxt;
  logic               w_step;
  mode_e              w_mode;
  logic [WIDTH-1:0]   w_inc, w_dec, w_clamp;

  assign w_mode  = mode_e'(bus.mode);
  assign w_inc   = r_count + WIDTH'(1);
  assign w_dec   = r_count - WIDTH'(1);
  assign w_clamp = (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;
  assign w_step  = bus.en && (r_p == bus.presc_div);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
      r_p     <= '0;
      r_dir   <= 1'b1;
      r_tick  <= 1'b0;
      r_tc    <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_p     <= w_p_nxt;
      r_dir   <= w_dir_nxt;
      r_tick  <= w_tick_nxt;
      r_tc    <= w_tc_nxt;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    w_p_nxt     = r_p;
    w_dir_nxt   = r_dir;
    w_tick_nxt  = 1'b0;
    w_tc_nxt    = 1'b0;
    if (bus.load) begin
      w_count_nxt = w_clamp;
      w_p_nxt     = '0;
      w_dir_nxt   = (w_mode != M_DOWN_WRAP);
    end else if (bus.en) begin
      // p wraps on its own when presc_div is lowered beneath it
      w_p_nxt = w_step ? '0 : r_p + PRESC_W'(1);
      if (w_step) begin
        w_tick_nxt = 1'b1;
        if (r_count > bus.max_val) begin
          w_count_nxt = (w_mode == M_UP_WRAP) ? '0 : bus.max_val;
          w_tc_nxt    = 1'b1;
          if (w_mode != M_PING_PONG) w_dir_nxt = (w_mode != M_DOWN_WRAP);
        end else begin
          case (w_mode)
            M_UP_WRAP: begin
              w_dir_nxt = 1'b1;
              if (r_count == bus.max_val) begin
                w_count_nxt = '0;
                w_tc_nxt    = 1'b1;
              end else begin
                w_count_nxt = w_inc;
              end
            end
            M_DOWN_WRAP: begin
              w_dir_nxt = 1'b0;
              if (r_count == '0) begin
                w_count_nxt = bus.max_val;
                w_tc_nxt    = 1'b1;
              end else begin
                w_count_nxt = w_dec;
              end
            end
            M_UP_SAT: begin
              w_dir_nxt = 1'b1;
              if (r_count < bus.max_val) begin
                w_count_nxt = w_inc;
                w_tc_nxt    = (w_inc == bus.max_val);
              end
            end
            M_PING_PONG: begin
              w_tc_nxt = 1'b0;
              if (bus.max_val == '0) begin
                w_count_nxt = '0;
                w_dir_nxt   = ~r_dir;
                w_tc_nxt    = 1'b1;
              end else if (r_dir) begin
                if (r_count < bus.max_val) begin
                  w_count_nxt = w_inc;
                end else begin
                  w_count_nxt = w_dec;
                  w_dir_nxt   = 1'b0;
                  w_tc_nxt    = 1'b1;
                end
              end else begin
                if (r_count != '0) begin
                  w_count_nxt = w_dec;
                end else begin
                  w_count_nxt = WIDTH'(1);
                  w_dir_nxt   = 1'b1;
                  w_tc_nxt    = 1'b1;
                end
              end
            end
            default: w_count_nxt = r_count;
          endcase
        end
      end
    end
  end

  assign bus.count     = r_count;
  assign bus.dir       = r_dir;
  assign bus.tick      = r_tick;
  assign bus.tc        = r_tc;
  assign bus.cmp_match = (r_count == bus.cmp_val);
endmodule

// File: tb/tb_counter_prog.sv
// tb/tb_counter_prog.sv - randomized and directed bench for counter_prog against a reference model
module tb_counter_prog;
  localparam int W  = 8;
  localparam int PW = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  int m_count, m_p, m_dir, m_tick, m_tc;

  counter_prog_if #(.WIDTH(W), .PRESC_W(PW)) bus ();

  counter_prog #(.WIDTH(W), .PRESC_W(PW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One counting step expressed as arithmetic over the range 0..mx.
  task automatic model_step();
    int mx, md, nxt, ndir;
    mx = int'(bus.max_val);
    md = int'(bus.mode);
    m_tick = 1;
    if (m_count > mx) begin
      m_count = (md == 0) ? 0 : mx;
      m_tc = 1;
      if (md != 3) m_dir = (md == 1) ? 0 : 1;
    end else if (md == 0) begin
      m_dir = 1;
      m_count = (m_count + 1) % (mx + 1);
      m_tc = (m_count == 0) ? 1 : 0;
    end else if (md == 1) begin
      m_dir = 0;
      m_tc = (m_count == 0) ? 1 : 0;
      m_count = (m_count + mx) % (mx + 1);
    end else if (md == 2) begin
      m_dir = 1;
      nxt = (m_count + 1 > mx) ? mx : m_count + 1;
      m_tc = (nxt != m_count && nxt == mx) ? 1 : 0;
      m_count = nxt;
    end else begin
      nxt = m_count + (m_dir ? 1 : -1);
      if (nxt < 0 || nxt > mx) begin
        ndir = 1 - m_dir;
        m_dir = ndir;
        m_tc = 1;
        m_count = (mx == 0) ? 0 : m_count + (ndir ? 1 : -1);
      end else begin
        m_count = nxt;
      end
    end
  endtask

  task automatic model_clk();
    m_tick = 0;
    m_tc = 0;
    if (rst) begin
      m_count = 0; m_p = 0; m_dir = 1;
    end else if (bus.load) begin
      m_count = (int'(bus.load_val) > int'(bus.max_val)) ? int'(bus.max_val) : int'(bus.load_val);
      m_p = 0;
      m_dir = (bus.mode == 2'b01) ? 0 : 1;
    end else if (bus.en) begin
      if (m_p == int'(bus.presc_div)) begin
        m_p = 0;
        model_step();
      end else begin
        m_p = (m_p + 1) % (1 << PW);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      model_clk();
      @(posedge clk);
      #1;
      chk("count", 32'(bus.count), 32'(m_count));
      chk("dir", 32'(bus.dir), 32'(m_dir));
      chk("tick", 32'(bus.tick), 32'(m_tick));
      chk("tc", 32'(bus.tc), 32'(m_tc));
      chk("cmp_match", 32'(bus.cmp_match), 32'(m_count == int'(bus.cmp_val)));
    end
  endtask

  task automatic do_load(input logic [1:0] md, input int mx, input int val);
    bus.mode = md; bus.max_val = W'(mx); bus.load_val = W'(val); bus.load = 1'b1;
    cyc(1);
    bus.load = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    m_count = 0; m_p = 0; m_dir = 1; m_tick = 0; m_tc = 0;
    rst = 1'b1;
    bus.en = 1'b0; bus.mode = 2'b00; bus.load = 1'b0; bus.load_val = '0;
    bus.presc_div = '0; bus.max_val = '0; bus.cmp_val = 8'd200;
    cyc(2);
    chk("reset_count", 32'(bus.count), 0);
    chk("reset_dir", 32'(bus.dir), 1);

    rst = 1'b0; bus.max_val = 8'd5; bus.en = 1'b1;
    cyc(14);
    chk("wrap6_after14", 32'(bus.count), 2);

    bus.presc_div = 4'd3;
    do_load(2'b00, 255, 0);
    cyc(8);
    chk("presc_two_steps", 32'(bus.count), 2);
    bus.en = 1'b0;
    cyc(5);
    chk("en_low_frozen", 32'(bus.count), 2);
    bus.en = 1'b1;
    cyc(8);
    chk("presc_resume", 32'(bus.count), 4);

    bus.presc_div = 4'd0;
    do_load(2'b10, 3, 0);
    cyc(5);
    chk("sat_hold", 32'(bus.count), 3);
    do_load(2'b01, 3, 0);
    cyc(5);
    chk("down_wrap", 32'(bus.count), 3);
    do_load(2'b11, 3, 0);
    cyc(6);
    chk("pingpong_bottom", 32'(bus.count), 0);
    chk("pingpong_dir_down", 32'(bus.dir), 0);

    do_load(2'b00, 100, 200);
    chk("load_clamp", 32'(bus.count), 100);
    do_load(2'b00, 100, 50);
    bus.max_val = 8'd20;
    cyc(1);
    chk("oor_count", 32'(bus.count), 0);
    chk("oor_tc", 32'(bus.tc), 1);

    bus.cmp_val = 8'd7;
    do_load(2'b00, 255, 5);
    cyc(4);

    do_load(2'b11, 5, 0);
    cyc(7);
    rst = 1'b1; bus.load = 1'b1; bus.load_val = 8'd9;
    cyc(1);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_dir", 32'(bus.dir), 1);
    chk("rst_tick", 32'(bus.tick), 0);
    chk("rst_tc", 32'(bus.tc), 0);
    rst = 1'b0; bus.load = 1'b0;
    cyc(2);
    chk("rst_resume_up", 32'(bus.count), 2);

    repeat (800) begin
      rst       = ($urandom_range(0, 59) == 0);
      bus.load  = ($urandom_range(0, 15) == 0);
      bus.en    = ($urandom_range(0, 3) != 0);
      bus.load_val = W'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0)
        bus.max_val = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 12));
      if ($urandom_range(0, 29) == 0) bus.presc_div = PW'($urandom_range(0, 3));
      bus.cmp_val = W'($urandom_range(0, 12));
      cyc(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/counter_prog.md
Name: counter_prog

Overview:
- Parametrised successor to the team's fixed 8-bit demo counter.
- Programmable-modulus counter with four counting modes, a cycle prescaler, synchronous load, a terminal-count pulse and a compare-match flag.
- Sits behind the top-level TinyTapeout wrapper, which maps ui_in/uio_in to the control inputs and count/flags to uo_out.

Parameters:
- WIDTH, 8, counter width in bits (2..16).
- PRESC_W, 4, prescaler divider width in bits (1..8).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  count enable; gates the prescaler and counting.
- mode  in  2  00 up-wrap, 01 down-wrap, 10 up-saturate, 11 ping-pong.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value loaded on load.
- presc_div  in  PRESC_W  step occurs every presc_div+1 enabled cycles.
- max_val  in  WIDTH  top of count range (range 0..max_val).
- cmp_val  in  WIDTH  compare value.
- count  out  WIDTH  current count (registered).
- dir  out  1  1 = counting up, 0 = counting down (registered).
- tick  out  1  registered, 1-cycle pulse on each counting step.
- tc  out  1  registered, 1-cycle terminal-count pulse.
- cmp_match  out  1  combinational: count == cmp_val.

Behaviour:
- Reset (rst=1 at edge): count=0, prescaler p=0, dir=1, tick=0, tc=0. Reset has priority over everything, including mid-count or mid-load.
- Priority after reset: load > step > hold.
- Load:
  - count <= min(load_val, max_val); p <= 0; dir <= 1 except in mode 01, where dir <= 0.
  - tick=0 and tc=0 on the load cycle.
  - load works regardless of en.
- Prescaler:
  - When en=0, p holds and no step occurs.
  - When en=1 and p != presc_div: p <= p+1.
  - When en=1 and p == presc_div: p <= 0 and this cycle is a step. presc_div=0 therefore steps every enabled cycle.
  - If presc_div is lowered below p, p continues incrementing and wraps naturally at 2^PRESC_W.
- A step registers tick=1 for one cycle; tick=0 on all other cycles. tc defaults to 0 each cycle.
- Out-of-range recovery: if count > max_val at a step (max_val lowered live):
  - Up-wrap: count <= 0.
  - Other modes: count <= max_val.
  - tc=1 in all modes.
  - This rule overrides the mode rules below.
- Mode 00, up-wrap: count==max_val -> count <= 0, tc=1; else count+1. dir=1.
- Mode 01, down-wrap: count==0 -> count <= max_val, tc=1; else count-1. dir=0.
- Mode 10, up-saturate:
  - count<max_val -> count+1; tc=1 only on the step that reaches max_val.
  - count==max_val -> hold, tc=0 (no repeated pulses).
  - dir=1.
- Mode 11, ping-pong:
  - dir=1: count<max_val -> count+1; at max_val -> dir <= 0, count <= max_val-1, tc=1.
  - dir=0: count>0 -> count-1; at 0 -> dir <= 1, count <= 1, tc=1.
  - max_val=0: count stays 0, tc=1 every step, dir toggles each step.
- max_val=0 in other modes: count stays 0; tc=1 every step in modes 00/01; never in mode 10.
- Mode change is sampled at the next step; count and dir are not reset by a mode change.
  - Entering mode 00 or 10 forces dir=1 on that step; entering mode 01 forces dir=0.
- Arithmetic is unsigned WIDTH-bit. No step may produce a value outside 0..max_val.
- cmp_match follows registered count combinationally, with no extra latency.

Test Plan:
- Reset, then mode=00, WIDTH=8, max_val=5, presc_div=0, en=1 for 14 cycles -> count 1,2,3,4,5,0,1,...; tc high exactly on the cycles count becomes 0; tick high every cycle.
- presc_div=3, mode=00, max_val=255 -> count increments every 4th enabled cycle with tick aligned. Dropping en for 5 cycles freezes count and p; the sequence resumes seamlessly afterwards.
- mode=10, max_val=3, from 0 -> count 1,2,3,3,3; a single tc pulse on the step to 3. mode=01 from 0 with max_val=3 -> 3 (tc),2,1,0,3 (tc).
- mode=11, max_val=3, from 0 -> 1,2,3,2,1,0,1,...; tc on reversals at 3 and at 0; dir toggles on the same steps.
- load=1 with load_val=200, max_val=100 -> count=100, p=0. At count=50 lower max_val to 20 in mode 00 -> next step count=0 with tc=1. cmp_val=7 -> cmp_match high only while count==7.
- Assert rst during ping-pong descent with load=1 on the same cycle -> count=0, dir=1, tick=0, tc=0 on the next cycle; counting resumes upward from 0.
